// File: rtl/l1_cache_pkg.sv
// rtl/l1_cache_pkg.sv - shared state encoding and memory-control constants for the L1 data cache
package l1_cache_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOOKUP    = 3'd1,
        WRITEBACK = 3'd2,
        FILL      = 3'd3,
        RESPOND   = 3'd4
    } cache_state_t;

    // data_mem access encodings (whole-word only)
    localparam logic [2:0] LC_NONE = 3'b000;
    localparam logic [2:0] LC_LW   = 3'b001;
    localparam logic [1:0] SC_NONE = 2'b00;
    localparam logic [1:0] SC_SW   = 2'b01;

endpackage

// File: rtl/l1_line_store.sv
// rtl/l1_line_store.sv - direct-mapped line storage (valid/dirty/tag/data arrays)
//
// Ports:
//   clk, n_reset          clock, async active-low reset (clears valid/dirty only)
//   rd_index              combinational read index
//   rd_valid/dirty/tag/data  contents of the addressed line
//   wr_en, wr_index       synchronous line write; always marks the line valid
//   wr_tag, wr_data, wr_dirty  new line contents
module l1_line_store #(
    parameter int index_bits = 4,
    parameter int tag_bits   = 26,
    parameter int data_bits  = 32
) (
    input  logic                  clk,
    input  logic                  n_reset,
    input  logic [index_bits-1:0] rd_index,
    output logic                  rd_valid,
    output logic                  rd_dirty,
    output logic [tag_bits-1:0]   rd_tag,
    output logic [data_bits-1:0]  rd_data,
    input  logic                  wr_en,
    input  logic [index_bits-1:0] wr_index,
    input  logic [tag_bits-1:0]   wr_tag,
    input  logic [data_bits-1:0]  wr_data,
    input  logic                  wr_dirty
);

    localparam int LINES = 1 << index_bits;

    logic [LINES-1:0]     valid_q;
    logic [LINES-1:0]     dirty_q;
    logic [tag_bits-1:0]  tag_q  [LINES];
    logic [data_bits-1:0] data_q [LINES];

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_index] <= 1'b1;
            dirty_q[wr_index] <= wr_dirty;
        end
    end

    // Tag and data are meaningless while valid=0, so they carry no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[wr_index]  <= wr_tag;
            data_q[wr_index] <= wr_data;
        end
    end

    assign rd_valid = valid_q[rd_index];
    assign rd_dirty = dirty_q[rd_index];
    assign rd_tag   = tag_q[rd_index];
    assign rd_data  = data_q[rd_index];

endmodule

// File: rtl/l1_dcache_ctrl.sv
// rtl/l1_dcache_ctrl.sv - direct-mapped write-back write-allocate L1 data-cache controller
//
// Ports:
//   clk, n_reset                  clock, async active-low reset
//   cpu_req/we/addr/wdata         request, sampled only in IDLE
//   cpu_rdata, cpu_ready          one-cycle completion pulse with load data (0 for stores)
//   busy                          high whenever the controller is not IDLE
//   mem_address, mem_load_control, mem_store_control, mem_wdata
//                                 word interface into data_mem (all registered)
//   mem_rdata                     combinational read data from data_mem
module l1_dcache_ctrl #(
    parameter int n          = 32,
    parameter int index_bits = 4
) (
    input  logic          clk,
    input  logic          n_reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [n-3:0]  cpu_addr,
    input  logic [n-1:0]  cpu_wdata,
    output logic [n-1:0]  cpu_rdata,
    output logic          cpu_ready,
    output logic          busy,
    output logic [n-3:0]  mem_address,
    output logic [2:0]    mem_load_control,
    output logic [1:0]    mem_store_control,
    output logic [n-1:0]  mem_wdata,
    input  logic [n-1:0]  mem_rdata
);

    import l1_cache_pkg::*;

    localparam int AW = n - 2;
    localparam int TW = AW - index_bits;

    cache_state_t state_q, state_d;

    logic [AW-1:0] req_addr_q;
    logic          req_we_q;
    logic [n-1:0]  req_wdata_q;

    logic [index_bits-1:0] req_index;
    logic [TW-1:0]         req_tag;

    logic          line_valid, line_dirty;
    logic [TW-1:0] line_tag;
    logic [n-1:0]  line_rdata;
    logic          line_we;
    logic [n-1:0]  line_wdata;
    logic          line_wdirty;
    logic          hit;

    // Next values of the registered outputs
    logic          ready_d;
    logic [n-1:0]  rdata_d;
    logic [AW-1:0] addr_d;
    logic [2:0]    lc_d;
    logic [1:0]    sc_d;
    logic [n-1:0]  wdata_d;

    assign req_index = req_addr_q[index_bits-1:0];
    assign req_tag   = req_addr_q[AW-1:index_bits];
    assign hit       = line_valid && (line_tag == req_tag);

    l1_line_store #(
        .index_bits (index_bits),
        .tag_bits   (TW),
        .data_bits  (n)
    ) u_line_store (
        .clk      (clk),
        .n_reset  (n_reset),
        .rd_index (req_index),
        .rd_valid (line_valid),
        .rd_dirty (line_dirty),
        .rd_tag   (line_tag),
        .rd_data  (line_rdata),
        .wr_en    (line_we),
        .wr_index (req_index),
        .wr_tag   (req_tag),
        .wr_data  (line_wdata),
        .wr_dirty (line_wdirty)
    );

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q           <= IDLE;
            req_addr_q        <= '0;
            req_we_q          <= 1'b0;
            req_wdata_q       <= '0;
            cpu_ready         <= 1'b0;
            cpu_rdata         <= '0;
            busy              <= 1'b0;
            mem_address       <= '0;
            mem_load_control  <= LC_NONE;
            mem_store_control <= SC_NONE;
            mem_wdata         <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && cpu_req) begin
                req_addr_q  <= cpu_addr;
                req_we_q    <= cpu_we;
                req_wdata_q <= cpu_wdata;
            end
            // All CPU/memory outputs come straight from flops so they are
            // glitch-free and fall to zero the instant reset asserts.
            cpu_ready         <= ready_d;
            cpu_rdata         <= rdata_d;
            busy              <= (state_d != IDLE);
            mem_address       <= addr_d;
            mem_load_control  <= lc_d;
            mem_store_control <= sc_d;
            mem_wdata         <= wdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        line_we     = 1'b0;
        line_wdata  = req_wdata_q;
        line_wdirty = 1'b1;
        ready_d     = 1'b0;
        rdata_d     = '0;
        addr_d      = '0;
        lc_d        = LC_NONE;
        sc_d        = SC_NONE;
        wdata_d     = '0;

        case (state_q)
            IDLE: begin
                if (cpu_req) begin
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (hit) begin
                    line_we = req_we_q;
                    state_d = RESPOND;
                    ready_d = 1'b1;
                    rdata_d = req_we_q ? '0 : line_rdata;
                end else if (line_valid && line_dirty) begin
                    state_d = WRITEBACK;
                    sc_d    = SC_SW;
                    addr_d  = {line_tag, req_index};
                    wdata_d = line_rdata;
                end else if (!req_we_q) begin
                    state_d = FILL;
                    lc_d    = LC_LW;
                    addr_d  = req_addr_q;
                end else begin
                    // Clean write miss: allocate without reading memory,
                    // the whole word is overwritten anyway.
                    line_we = 1'b1;
                    state_d = RESPOND;
                    ready_d = 1'b1;
                end
            end
            WRITEBACK: begin
                if (req_we_q) begin
                    line_we = 1'b1;
                    state_d = RESPOND;
                    ready_d = 1'b1;
                end else begin
                    state_d = FILL;
                    lc_d    = LC_LW;
                    addr_d  = req_addr_q;
                end
            end
            FILL: begin
                line_we     = 1'b1;
                line_wdata  = mem_rdata;
                line_wdirty = 1'b0;
                state_d     = RESPOND;
                ready_d     = 1'b1;
                rdata_d     = mem_rdata;
            end
            RESPOND: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_l1_dcache_ctrl.sv
// tb/tb_l1_dcache_ctrl.sv - self-checking bench for l1_dcache_ctrl
module tb_l1_dcache_ctrl;

    import l1_cache_pkg::*;

    localparam int N  = 32;
    localparam int IB = 4;
    localparam int AW = N - 2;

    logic          clk = 1'b0;
    logic          n_reset;
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [N-1:0]  cpu_wdata;
    logic [N-1:0]  cpu_rdata;
    logic          cpu_ready;
    logic          busy;
    logic [AW-1:0] mem_address;
    logic [2:0]    mem_load_control;
    logic [1:0]    mem_store_control;
    logic [N-1:0]  mem_wdata;
    logic [N-1:0]  mem_rdata;

    always #5 clk = ~clk;

    l1_dcache_ctrl #(.n(N), .index_bits(IB)) dut (
        .clk               (clk),
        .n_reset           (n_reset),
        .cpu_req           (cpu_req),
        .cpu_we            (cpu_we),
        .cpu_addr          (cpu_addr),
        .cpu_wdata         (cpu_wdata),
        .cpu_rdata         (cpu_rdata),
        .cpu_ready         (cpu_ready),
        .busy              (busy),
        .mem_address       (mem_address),
        .mem_load_control  (mem_load_control),
        .mem_store_control (mem_store_control),
        .mem_wdata         (mem_wdata),
        .mem_rdata         (mem_rdata)
    );

    // data_mem model: 256 words, combinational read, write at the clock edge
    logic [31:0] dmem [256];
    logic        pl_en;
    logic [7:0]  pl_addr;
    logic [31:0] pl_data;

    assign mem_rdata = dmem[mem_address[7:0]];

    always @(posedge clk) begin
        if (pl_en) dmem[pl_addr] <= pl_data;
        else if (mem_store_control == SC_SW) dmem[mem_address[7:0]] <= mem_wdata;
    end

    // Reference model: what the cache holds and what memory should hold
    logic [31:0] ref_mem  [256];
    bit          ref_v    [16];
    bit          ref_d    [16];
    logic [25:0] ref_t    [16];
    logic [31:0] ref_data [16];

    typedef struct {
        bit          we;
        logic [29:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic [31:0] rdata;
        int          wb;
        logic [29:0] wb_addr;
        logic [31:0] wb_data;
        int          fill;
        logic [29:0] fill_addr;
        int          busy_gaps;
        bit          after_ok;
    } vec_t;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input bit we, input logic [29:0] addr, input logic [31:0] wdata,
                                input int lat, input logic [31:0] rdata,
                                input int wb, input logic [29:0] wb_addr, input logic [31:0] wb_data,
                                input int fill, input logic [29:0] fill_addr);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wdata; v.lat = lat; v.rdata = rdata;
        v.wb = wb; v.wb_addr = wb_addr; v.wb_data = wb_data;
        v.fill = fill; v.fill_addr = fill_addr; v.busy_gaps = 0; v.after_ok = 1'b1;
        return v;
    endfunction

    task automatic ref_invalidate();
        for (int i = 0; i < 16; i++) begin
            ref_v[i] = 1'b0;
            ref_d[i] = 1'b0;
        end
    endtask

    task automatic ref_access(input bit we, input logic [29:0] addr, input logic [31:0] wdata, output vec_t e);
        int          idx;
        logic [25:0] tag;
        bit          dirty_victim;
        idx = int'(addr[3:0]);
        tag = addr[29:4];
        e = mk(we, addr, wdata, 0, 32'h0, 0, 30'h0, 32'h0, 0, 30'h0);
        if (ref_v[idx] && ref_t[idx] == tag) begin
            e.lat = 2;
            if (we) begin
                ref_data[idx] = wdata;
                ref_d[idx] = 1'b1;
            end else begin
                e.rdata = ref_data[idx];
            end
        end else begin
            dirty_victim = ref_v[idx] && ref_d[idx];
            if (dirty_victim) begin
                e.wb = 1;
                e.wb_addr = {ref_t[idx], addr[3:0]};
                e.wb_data = ref_data[idx];
                ref_mem[e.wb_addr[7:0]] = ref_data[idx];
            end
            ref_v[idx] = 1'b1;
            ref_t[idx] = tag;
            if (we) begin
                e.lat = dirty_victim ? 3 : 2;
                ref_data[idx] = wdata;
                ref_d[idx] = 1'b1;
            end else begin
                e.lat = dirty_victim ? 4 : 3;
                e.fill = 1;
                e.fill_addr = addr;
                ref_data[idx] = ref_mem[addr[7:0]];
                ref_d[idx] = 1'b0;
                e.rdata = ref_data[idx];
            end
        end
    endtask

    // Issues one request from an IDLE cycle and observes it until the cycle after cpu_ready.
    task automatic run_txn(input bit we, input logic [29:0] addr, input logic [31:0] wdata, output vec_t o);
        bit done;
        o = mk(we, addr, wdata, -1, 32'h0, 0, 30'h0, 32'h0, 0, 30'h0);
        o.after_ok = 1'b0;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        @(posedge clk); #1;
        cpu_req = 1'b0; cpu_we = 1'($urandom); cpu_addr = 30'($urandom); cpu_wdata = $urandom;
        done = 1'b0;
        for (int cyc = 1; cyc <= 8 && !done; cyc++) begin
            if (mem_store_control == SC_SW) begin
                o.wb++;
                o.wb_addr = mem_address;
                o.wb_data = mem_wdata;
            end else if (mem_store_control != SC_NONE) begin
                o.wb += 10;
            end
            if (mem_load_control == LC_LW) begin
                o.fill++;
                o.fill_addr = mem_address;
            end else if (mem_load_control != LC_NONE) begin
                o.fill += 10;
            end
            if (!busy) o.busy_gaps++;
            if (cpu_ready) begin
                o.lat = cyc;
                o.rdata = cpu_rdata;
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        o.after_ok = !busy && !cpu_ready && mem_load_control == LC_NONE && mem_store_control == SC_NONE;
    endtask

    task automatic compare_txn(input string tag, input vec_t e, input vec_t o);
        check({tag, ".latency"}, 64'(o.lat), 64'(e.lat));
        check({tag, ".rdata"}, 64'(o.rdata), 64'(e.rdata));
        check({tag, ".wb_count"}, 64'(o.wb), 64'(e.wb));
        if (e.wb != 0) begin
            check({tag, ".wb_addr"}, 64'(o.wb_addr), 64'(e.wb_addr));
            check({tag, ".wb_data"}, 64'(o.wb_data), 64'(e.wb_data));
        end
        check({tag, ".fill_count"}, 64'(o.fill), 64'(e.fill));
        if (e.fill != 0) check({tag, ".fill_addr"}, 64'(o.fill_addr), 64'(e.fill_addr));
        check({tag, ".busy_gaps"}, 64'(o.busy_gaps), 64'(e.busy_gaps));
        check({tag, ".idle_after"}, 64'(o.after_ok), 64'(e.after_ok));
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, ".cpu_ready"}, 64'(cpu_ready), 64'h0);
        check({tag, ".cpu_rdata"}, 64'(cpu_rdata), 64'h0);
        check({tag, ".busy"}, 64'(busy), 64'h0);
        check({tag, ".mem_address"}, 64'(mem_address), 64'h0);
        check({tag, ".mem_ctrl"}, 64'({mem_load_control, mem_store_control}), 64'h0);
        check({tag, ".mem_wdata"}, 64'(mem_wdata), 64'h0);
    endtask

    vec_t tbl [7];
    vec_t e, o;
    logic [9:0] ready_mask, idle_mask;
    int mem_activity, rdata_bad, mism;
    logic [31:0] old_word;

    initial begin
        n_reset = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        pl_en = 1'b1; pl_addr = '0; pl_data = '0;

        // Preload memory (DUT held in reset meanwhile)
        for (int a = 0; a < 256; a++) begin
            pl_addr = 8'(a);
            pl_data = (a == 8'h05) ? 32'hDEADBEEF : (a == 8'h25) ? 32'h25252525 : $urandom;
            ref_mem[a] = pl_data;
            @(posedge clk); #1;
        end
        pl_en = 1'b0;
        check_outputs_zero("reset");
        n_reset = 1'b1;
        ref_invalidate();
        @(posedge clk); #1;
        check("post_reset.busy", 64'(busy), 64'h0);

        // Directed vectors: inputs and expected observations
        tbl[0] = mk(0, 30'h05, 32'h0,        3, 32'hDEADBEEF, 0, 30'h0,  32'h0,        1, 30'h05);
        tbl[1] = mk(0, 30'h05, 32'h0,        2, 32'hDEADBEEF, 0, 30'h0,  32'h0,        0, 30'h0);
        tbl[2] = mk(1, 30'h15, 32'h12345678, 2, 32'h0,        0, 30'h0,  32'h0,        0, 30'h0);
        tbl[3] = mk(0, 30'h25, 32'h0,        4, 32'h25252525, 1, 30'h15, 32'h12345678, 1, 30'h25);
        tbl[4] = mk(1, 30'h35, 32'hCAFEF00D, 2, 32'h0,        0, 30'h0,  32'h0,        0, 30'h0);
        tbl[5] = mk(1, 30'h05, 32'h11112222, 3, 32'h0,        1, 30'h35, 32'hCAFEF00D, 0, 30'h0);
        tbl[6] = mk(0, 30'h05, 32'h0,        2, 32'h11112222, 0, 30'h0,  32'h0,        0, 30'h0);
        for (int i = 0; i < 7; i++) begin
            run_txn(tbl[i].we, tbl[i].addr, tbl[i].wdata, o);
            ref_access(tbl[i].we, tbl[i].addr, tbl[i].wdata, e);
            compare_txn($sformatf("vec%0d", i), tbl[i], o);
        end
        check("dmem_0x15", 64'(dmem[8'h15]), 64'h12345678);
        check("dmem_0x35", 64'(dmem[8'h35]), 64'hCAFEF00D);

        // Reset during FILL: outputs drop at once, cached state is lost
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 30'h06;
        @(posedge clk); #1;
        cpu_req = 1'b0;
        @(posedge clk); #1;
        check("fill_abort.in_fill", 64'(mem_load_control), 64'(LC_LW));
        n_reset = 1'b0;
        #1;
        check_outputs_zero("fill_abort");
        @(posedge clk); #1;
        n_reset = 1'b1;
        ref_invalidate();
        run_txn(0, 30'h05, 32'h0, o);
        ref_access(0, 30'h05, 32'h0, e);
        compare_txn("after_reset", mk(0, 30'h05, 32'h0, 3, 32'hDEADBEEF, 0, 30'h0, 32'h0, 1, 30'h05), o);

        // Reset during WRITEBACK: the memory write must not happen
        run_txn(1, 30'h07, 32'h77770000, o);
        ref_access(1, 30'h07, 32'h77770000, e);
        compare_txn("dirty_07", e, o);
        old_word = dmem[8'h07];
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 30'h17;
        @(posedge clk); #1;
        cpu_req = 1'b0;
        @(posedge clk); #1;
        check("wb_abort.in_wb", 64'({mem_store_control, mem_address}), 64'({SC_SW, 30'h07}));
        n_reset = 1'b0;
        #1;
        check("wb_abort.store_ctrl", 64'(mem_store_control), 64'(SC_NONE));
        @(posedge clk); #1;
        check("wb_abort.dmem_07", 64'(dmem[8'h07]), 64'(old_word));
        n_reset = 1'b1;
        ref_invalidate();

        // Continuous cpu_req on a hit: one response every 3 cycles
        run_txn(0, 30'h05, 32'h0, o);
        ref_access(0, 30'h05, 32'h0, e);
        compare_txn("warm_05", e, o);
        ready_mask = '0; idle_mask = '0; mem_activity = 0; rdata_bad = 0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 30'h05;
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk); #1;
            ready_mask[k] = cpu_ready;
            idle_mask[k] = !busy;
            if (mem_load_control != LC_NONE || mem_store_control != SC_NONE) mem_activity++;
            if (cpu_ready && cpu_rdata != 32'hDEADBEEF) rdata_bad++;
        end
        cpu_req = 1'b0;
        check("held_req.ready_mask", 64'(ready_mask), 64'h124);
        check("held_req.idle_mask", 64'(idle_mask), 64'h248);
        check("held_req.mem_activity", 64'(mem_activity), 64'h0);
        check("held_req.rdata", 64'(rdata_bad), 64'h0);

        // Randomized traffic against the reference model
        for (int t = 0; t < 400; t++) begin
            bit          we;
            logic [29:0] addr;
            logic [31:0] wd;
            we   = 1'($urandom_range(0, 1));
            addr = 30'($urandom_range(0, 63));
            wd   = $urandom;
            ref_access(we, addr, wd, e);
            run_txn(we, addr, wd, o);
            compare_txn($sformatf("rand%0d", t), e, o);
        end

        mism = 0;
        for (int a = 0; a < 256; a++) begin
            if (dmem[a] !== ref_mem[a]) mism++;
        end
        check("mem_image", 64'(mism), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/l1_dcache_ctrl.md
# l1_dcache_ctrl

Direct-mapped, write-back, write-allocate L1 data-cache controller sitting between the core's load/store unit and `data_mem`. It is the initiator on the data-memory word interface. It drives `address`/`load_control`/`store_control`/`dmem_wdata` into `data_mem` and consumes its combinational `dmem_rdata`. Lines are one 32-bit word, and all memory traffic is whole-word (LW/SW). Sub-word extension and merging stay in the core.

## Interface
- `n`, 32, data width; word address width is `n-2`
- `index_bits`, 4, line index width; the cache holds `1<<index_bits` lines
- `clk`  in  1  system clock, rising edge
- `n_reset`  in  1  asynchronous, active-low reset
- `cpu_req`  in  1  request valid; sampled only in IDLE
- `cpu_we`  in  1  1 = word store, 0 = word load
- `cpu_addr`  in  n-2  word address; index = `[index_bits-1:0]`, tag = `[n-3:index_bits]`
- `cpu_wdata`  in  32  store data
- `cpu_rdata`  out  32  load data; valid while `cpu_ready`=1
- `cpu_ready`  out  1  one-cycle completion pulse
- `busy`  out  1  high in every state except IDLE
- `mem_address`  out  n-2  word address to `data_mem`
- `mem_load_control`  out  3  3'b001 = LW, 3'b000 = idle
- `mem_store_control`  out  2  2'b01 = SW, 2'b00 = idle
- `mem_wdata`  out  32  write-back data
- `mem_rdata`  in  32  combinational read data from `data_mem`

## Operation
- Per-line state: `valid`, `dirty`, tag, data.
- IDLE: when `cpu_req`=1, capture addr/we/wdata into request registers and go to LOOKUP. The CPU need not hold its inputs afterwards.
- LOOKUP: hit = valid && tag match.
  - Read hit: go to RESPOND.
  - Write hit: write data, set dirty, go to RESPOND.
  - Miss with a dirty victim: go to WRITEBACK.
  - Clean read miss: go to FILL.
  - Clean write miss: install tag and `cpu_wdata`, set valid=1 and dirty=1, go to RESPOND. No memory traffic.
- WRITEBACK (1 cycle): drive `mem_store_control`=01, `mem_address`={victim tag, index}, `mem_wdata`=victim data. `data_mem` commits the write at the closing edge. Then go to FILL for a read, or install-and-RESPOND for a write, as in LOOKUP.
- FILL (1 cycle): drive `mem_load_control`=001 and `mem_address`=request address. At the closing edge, capture `mem_rdata` into the line with valid=1, dirty=0. Go to RESPOND.
- RESPOND (1 cycle): `cpu_ready`=1. `cpu_rdata` = line data for reads, 0 for writes. Go to IDLE.
- In all states other than WRITEBACK and FILL, all `mem_*` outputs are 0.
- `cpu_req` outside IDLE is ignored. No queuing.

## Timing
- Accept edge = cycle 0, when IDLE sees `cpu_req`.
- Latency to `cpu_ready`:
  - Hit: cycle 2
  - Clean read miss: cycle 3
  - Dirty read miss: cycle 4
  - Clean write miss: cycle 2
  - Dirty write miss: cycle 3
- Back-to-back throughput: a new request can be accepted in the cycle after RESPOND.
- `mem_*` outputs are asserted for exactly one cycle per memory access and decoded from registered state. They must be glitch-free relative to `clk`.
- Reset values: state=IDLE, all valid=0, all dirty=0, `cpu_ready`=0, `cpu_rdata`=0, `busy`=0, all `mem_*`=0. Tag and data arrays are not reset.
- Reset asserted mid-operation: outputs drop to reset values immediately and the transaction is lost. If reset is asserted in WRITEBACK before the clock edge, the memory write is not issued.
- The same address is used for victim and request only when tags are equal, which is a hit. No self-eviction case exists.

## Structure
- Package `l1_cache_pkg` holds:
  - the state enum `cache_state_t` (IDLE, LOOKUP, WRITEBACK, FILL, RESPOND)
  - constants `LC_NONE`=3'b000, `LC_LW`=3'b001, `SC_NONE`=2'b00, `SC_SW`=2'b01
- Sub-module `l1_line_store` holds the valid/dirty/tag/data arrays. It has asynchronous read, synchronous write, and asynchronous reset of valid/dirty only.
- `l1_dcache_ctrl` holds the FSM and the request registers, and drives the memory interface.

## Test plan
- Reset; `dmem[0x05]`=0xDEADBEEF; read 0x05 → `mem_load_control`=001, `mem_address`=0x05 in cycle 2 only; `cpu_ready`=1 and `cpu_rdata`=0xDEADBEEF in cycle 3.
- Read 0x05 again → hit, `cpu_ready` in cycle 2 with 0xDEADBEEF; `mem_*` stay 0 throughout.
- Write 0x15 (index 5, tag 1) with data 0x12345678, line 5 clean → no memory traffic; `cpu_ready` in cycle 2; line 5 is dirty.
- Read 0x25 → cycle 2: `mem_store_control`=01, `mem_address`=0x15, `mem_wdata`=0x12345678; cycle 3: FILL from 0x25; cycle 4: `cpu_ready`. `dmem[0x15]` now equals 0x12345678.
- Assert `n_reset` during FILL → all outputs drop to 0 immediately. After release, reading 0x05 misses again (cycle-3 response).
- Hold `cpu_req`=1 continuously with read 0x05 → exactly one `cpu_ready` per accept, spaced 3 cycles apart on hits; `busy`=0 only in the accept cycles.
